// File: rtl/cpu_core_pkg.sv
// Shared decode constants and enums for the cpu_core single-cycle RV32I core.
package cpu_core_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [6:0] {
        OPC_OP     = 7'b0110011,
        OPC_OP_IMM = 7'b0010011,
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111,
        OPC_BRANCH = 7'b1100011
    } opcode_e;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND,
        ALU_PASS_B
    } alu_op_e;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [2:0] F3_JALR = 3'b000;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    // alt selects SUB/SRA; callers only raise it where that encoding is legal
    function automatic alu_op_e alu_op_decode(input logic [2:0] f3, input logic alt);
        alu_op_e op;
        op = ALU_ADD;
        case (f3)
            F3_ADD_SUB: op = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:     op = ALU_SLL;
            F3_SLT:     op = ALU_SLT;
            F3_SLTU:    op = ALU_SLTU;
            F3_XOR:     op = ALU_XOR;
            F3_SRL_SRA: op = alt ? ALU_SRA : ALU_SRL;
            F3_OR:      op = ALU_OR;
            F3_AND:     op = ALU_AND;
            default:    op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/cpu_core_alu.sv
// Combinational ALU for cpu_core: arithmetic/logic/shift result plus compare flags.
module cpu_core_alu
    import cpu_core_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    input  alu_op_e         i_op,
    output logic [XLEN-1:0] o_result,
    output logic            o_eq,
    output logic            o_lt,
    output logic            o_ltu
);

    logic [4:0] w_shamt;

    assign w_shamt = i_b[4:0];
    assign o_eq    = (i_a == i_b);
    assign o_lt    = ($signed(i_a) < $signed(i_b));
    assign o_ltu   = (i_a < i_b);

    always_comb begin
        o_result = '0;
        case (i_op)
            ALU_ADD:    o_result = i_a + i_b;
            ALU_SUB:    o_result = i_a - i_b;
            ALU_SLL:    o_result = i_a << w_shamt;
            ALU_SLT:    o_result = {{(XLEN-1){1'b0}}, o_lt};
            ALU_SLTU:   o_result = {{(XLEN-1){1'b0}}, o_ltu};
            ALU_XOR:    o_result = i_a ^ i_b;
            ALU_SRL:    o_result = i_a >> w_shamt;
            ALU_SRA:    o_result = $unsigned($signed(i_a) >>> w_shamt);
            ALU_OR:     o_result = i_a | i_b;
            ALU_AND:    o_result = i_a & i_b;
            ALU_PASS_B: o_result = i_b;
            default:    o_result = '0;
        endcase
    end

endmodule

// File: rtl/cpu_core.sv
// Single-cycle RV32I integer core with debug-writable instruction memory.
// Optional macro CPU_CORE_DBG_REGFILE_EN adds a combinational register-file read port.
module cpu_core
    import cpu_core_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int IMEM_DEPTH = 256
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            dbg_wr_en,
    input  logic [XLEN-1:0] dbg_addr,
    input  logic [XLEN-1:0] dbg_instr
`ifdef CPU_CORE_DBG_REGFILE_EN
    ,
    input  logic [4:0]      dbg_reg_sel,
    output logic [XLEN-1:0] dbg_reg_data
`endif
);

    localparam int IDX_W = $clog2(IMEM_DEPTH);

    // Words are stored XOR NOP_INSTR so an all-zero power-up state decodes as NOP.
    logic [XLEN-1:0] r_imem [IMEM_DEPTH];
    logic [XLEN-1:0] r_regs [32];
    logic [XLEN-1:0] r_pc;

    logic [XLEN-1:0] w_instr;
    logic [6:0]      w_opcode;
    logic [4:0]      w_rd;
    logic [4:0]      w_rs1;
    logic [4:0]      w_rs2;
    logic [2:0]      w_f3;
    logic [6:0]      w_f7;
    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_imm_b;
    logic [XLEN-1:0] w_imm_u;
    logic [XLEN-1:0] w_imm_j;
    logic [XLEN-1:0] w_rs1_val;
    logic [XLEN-1:0] w_rs2_val;
    logic [XLEN-1:0] w_pc_plus4;
    logic [XLEN-1:0] w_pc_target;
    logic [XLEN-1:0] w_alu_a;
    logic [XLEN-1:0] w_alu_b;
    alu_op_e         w_alu_op;
    logic [XLEN-1:0] w_alu_res;
    logic            w_eq;
    logic            w_lt;
    logic            w_ltu;
    logic            w_rd_we;
    logic [XLEN-1:0] w_wb_val;
    logic [XLEN-1:0] w_next_pc;
    logic            w_dbg_in_range;

    assign w_instr  = r_imem[r_pc[IDX_W+1:2]] ^ NOP_INSTR;
    assign w_opcode = w_instr[6:0];
    assign w_rd     = w_instr[11:7];
    assign w_f3     = w_instr[14:12];
    assign w_rs1    = w_instr[19:15];
    assign w_rs2    = w_instr[24:20];
    assign w_f7     = w_instr[31:25];

    assign w_imm_i = {{20{w_instr[31]}}, w_instr[31:20]};
    assign w_imm_b = {{19{w_instr[31]}}, w_instr[31], w_instr[7], w_instr[30:25], w_instr[11:8], 1'b0};
    assign w_imm_u = {w_instr[31:12], 12'b0};
    assign w_imm_j = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12], w_instr[20], w_instr[30:21], 1'b0};

    assign w_rs1_val   = (w_rs1 == 5'd0) ? '0 : r_regs[w_rs1];
    assign w_rs2_val   = (w_rs2 == 5'd0) ? '0 : r_regs[w_rs2];
    assign w_pc_plus4  = r_pc + 32'd4;
    assign w_pc_target = r_pc + ((w_opcode == OPC_JAL) ? w_imm_j : w_imm_b);

    cpu_core_alu #(.XLEN(XLEN)) u_alu (
        .i_a      (w_alu_a),
        .i_b      (w_alu_b),
        .i_op     (w_alu_op),
        .o_result (w_alu_res),
        .o_eq     (w_eq),
        .o_lt     (w_lt),
        .o_ltu    (w_ltu)
    );

    always_comb begin
        w_alu_a   = w_rs1_val;
        w_alu_b   = w_rs2_val;
        w_alu_op  = ALU_ADD;
        w_rd_we   = 1'b0;
        w_wb_val  = w_alu_res;
        w_next_pc = w_pc_plus4;
        case (w_opcode)
            OPC_OP: begin
                if (w_f7 == F7_BASE ||
                    (w_f7 == F7_ALT && (w_f3 == F3_ADD_SUB || w_f3 == F3_SRL_SRA))) begin
                    w_alu_op = alu_op_decode(w_f3, w_f7[5]);
                    w_rd_we  = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                w_alu_b  = w_imm_i;
                // imm[10] only means "arithmetic" for right shifts; ADDI etc. ignore it
                w_alu_op = alu_op_decode(w_f3, (w_f3 == F3_SRL_SRA) && w_f7[5]);
                if (w_f3 == F3_SLL)
                    w_rd_we = (w_f7 == F7_BASE);
                else if (w_f3 == F3_SRL_SRA)
                    w_rd_we = (w_f7 == F7_BASE) || (w_f7 == F7_ALT);
                else
                    w_rd_we = 1'b1;
            end
            OPC_LUI: begin
                w_alu_b  = w_imm_u;
                w_alu_op = ALU_PASS_B;
                w_rd_we  = 1'b1;
            end
            OPC_AUIPC: begin
                w_alu_a = r_pc;
                w_alu_b = w_imm_u;
                w_rd_we = 1'b1;
            end
            OPC_JAL: begin
                w_rd_we   = 1'b1;
                w_wb_val  = w_pc_plus4;
                w_next_pc = w_pc_target;
            end
            OPC_JALR: begin
                if (w_f3 == F3_JALR) begin
                    w_alu_b   = w_imm_i;
                    w_rd_we   = 1'b1;
                    w_wb_val  = w_pc_plus4;
                    w_next_pc = {w_alu_res[XLEN-1:1], 1'b0};
                end
            end
            OPC_BRANCH: begin
                case (w_f3)
                    F3_BEQ:  if (w_eq)   w_next_pc = w_pc_target;
                    F3_BNE:  if (!w_eq)  w_next_pc = w_pc_target;
                    F3_BLT:  if (w_lt)   w_next_pc = w_pc_target;
                    F3_BGE:  if (!w_lt)  w_next_pc = w_pc_target;
                    F3_BLTU: if (w_ltu)  w_next_pc = w_pc_target;
                    F3_BGEU: if (!w_ltu) w_next_pc = w_pc_target;
                    default: w_next_pc = w_pc_plus4;
                endcase
            end
            default: w_rd_we = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= '0;
            for (int unsigned i = 0; i < 32; i++)
                r_regs[i] <= '0;
        end else begin
            r_pc <= w_next_pc;
            if (w_rd_we && w_rd != 5'd0)
                r_regs[w_rd] <= w_wb_val;
        end
    end

    // Instruction memory is outside the reset domain; debug writes land in or out of reset.
    assign w_dbg_in_range = ((dbg_addr >> (IDX_W + 2)) == '0);

    always_ff @(posedge clk) begin
        if (dbg_wr_en && w_dbg_in_range)
            r_imem[dbg_addr[IDX_W+1:2]] <= dbg_instr ^ NOP_INSTR;
    end

`ifdef CPU_CORE_DBG_REGFILE_EN
    assign dbg_reg_data = (dbg_reg_sel == 5'd0) ? '0 : r_regs[dbg_reg_sel];
`endif

endmodule

// File: tb/tb_cpu_core.sv
// Directed self-checking bench for cpu_core: table of single-instruction vectors plus program sequences.
module tb_cpu_core;

    logic        clk = 1'b0;
    logic        rst;
    logic        dbg_wr_en;
    logic [31:0] dbg_addr;
    logic [31:0] dbg_instr;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    always #5 clk = ~clk;

    cpu_core #(.XLEN(32), .IMEM_DEPTH(256)) dut (
        .clk       (clk),
        .rst       (rst),
        .dbg_wr_en (dbg_wr_en),
        .dbg_addr  (dbg_addr),
        .dbg_instr (dbg_instr)
    );

    typedef struct {
        string       name;
        logic [31:0] instr;
        int unsigned rd;
        logic [31:0] exp_rd;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] opc);
        return {imm, rs1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                          input logic [6:0] opc);
        return {imm, rd, opc};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
    endfunction

    function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [11:0] imm);
        return enc_i(imm, rs1, 3'd0, rd, 7'h13);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // All tasks enter and leave just after a falling edge.
    task automatic imem_write(input logic [31:0] addr, input logic [31:0] instr);
        dbg_wr_en = 1'b1;
        dbg_addr  = addr;
        dbg_instr = instr;
        @(negedge clk);
        dbg_wr_en = 1'b0;
    endtask

    task automatic run(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [31:0] xreg(input int unsigned i);
        return dut.r_regs[i];
    endfunction

    initial begin
        int unsigned nz;
        rst       = 1'b1;
        dbg_wr_en = 1'b0;
        dbg_addr  = '0;
        dbg_instr = '0;
        @(negedge clk);

        check("reset_pc", dut.r_pc, 32'd0);
        check("reset_x5", xreg(5), 32'd0);

        // Untouched memory powers up as NOP
        rst = 1'b0;
        run(3);
        check("powerup_pc", dut.r_pc, 32'd12);
        nz = 0;
        for (int unsigned i = 0; i < 32; i++)
            if (xreg(i) != 32'd0) nz++;
        check("powerup_regs_nonzero", 32'(nz), 32'd0);
        rst = 1'b1;

        // Setup: x1=0x80000005, x2=0xFFFFFFFD, x3=7; vector instruction sits at 0x10
        imem_write(32'h00, enc_u(20'h80000, 5'd1, 7'h37));
        imem_write(32'h04, addi(5'd1, 5'd1, 12'h005));
        imem_write(32'h08, addi(5'd2, 5'd0, 12'hFFD));
        imem_write(32'h0C, addi(5'd3, 5'd0, 12'h007));

        vecs.push_back('{"add",      enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd10), 10, 32'h80000002, 32'd20});
        vecs.push_back('{"sub",      enc_r(7'h20, 5'd3, 5'd1, 3'd0, 5'd10), 10, 32'h7FFFFFFE, 32'd20});
        vecs.push_back('{"sll",      enc_r(7'h00, 5'd3, 5'd3, 3'd1, 5'd10), 10, 32'h00000380, 32'd20});
        vecs.push_back('{"slt",      enc_r(7'h00, 5'd3, 5'd1, 3'd2, 5'd10), 10, 32'h00000001, 32'd20});
        vecs.push_back('{"sltu",     enc_r(7'h00, 5'd3, 5'd1, 3'd3, 5'd10), 10, 32'h00000000, 32'd20});
        vecs.push_back('{"sltu_rev", enc_r(7'h00, 5'd1, 5'd3, 3'd3, 5'd10), 10, 32'h00000001, 32'd20});
        vecs.push_back('{"xor",      enc_r(7'h00, 5'd2, 5'd1, 3'd4, 5'd10), 10, 32'h7FFFFFF8, 32'd20});
        vecs.push_back('{"srl",      enc_r(7'h00, 5'd3, 5'd1, 3'd5, 5'd10), 10, 32'h01000000, 32'd20});
        vecs.push_back('{"sra",      enc_r(7'h20, 5'd3, 5'd1, 3'd5, 5'd10), 10, 32'hFF000000, 32'd20});
        vecs.push_back('{"or",       enc_r(7'h00, 5'd3, 5'd1, 3'd6, 5'd10), 10, 32'h80000007, 32'd20});
        vecs.push_back('{"and",      enc_r(7'h00, 5'd3, 5'd2, 3'd7, 5'd10), 10, 32'h00000005, 32'd20});
        vecs.push_back('{"addi_min", addi(5'd10, 5'd2, 12'h800),                     10, 32'hFFFFF7FD, 32'd20});
        vecs.push_back('{"addi_b10", addi(5'd10, 5'd3, 12'h400),                     10, 32'h00000407, 32'd20});
        vecs.push_back('{"slti",     enc_i(12'hFFE, 5'd2, 3'd2, 5'd10, 7'h13),       10, 32'h00000001, 32'd20});
        vecs.push_back('{"sltiu",    enc_i(12'hFFF, 5'd3, 3'd3, 5'd10, 7'h13),       10, 32'h00000001, 32'd20});
        vecs.push_back('{"xori",     enc_i(12'hFFF, 5'd3, 3'd4, 5'd10, 7'h13),       10, 32'hFFFFFFF8, 32'd20});
        vecs.push_back('{"ori",      enc_i(12'h100, 5'd3, 3'd6, 5'd10, 7'h13),       10, 32'h00000107, 32'd20});
        vecs.push_back('{"andi",     enc_i(12'h0FF, 5'd1, 3'd7, 5'd10, 7'h13),       10, 32'h00000005, 32'd20});
        vecs.push_back('{"slli",     enc_i(12'h001, 5'd1, 3'd1, 5'd10, 7'h13),       10, 32'h0000000A, 32'd20});
        vecs.push_back('{"srli",     enc_i(12'h01F, 5'd1, 3'd5, 5'd10, 7'h13),       10, 32'h00000001, 32'd20});
        vecs.push_back('{"srai",     enc_i(12'h41F, 5'd1, 3'd5, 5'd10, 7'h13),       10, 32'hFFFFFFFF, 32'd20});
        vecs.push_back('{"lui",      enc_u(20'hABCDE, 5'd10, 7'h37),                 10, 32'hABCDE000, 32'd20});
        vecs.push_back('{"auipc",    enc_u(20'h00001, 5'd10, 7'h17),                 10, 32'h00001010, 32'd20});
        vecs.push_back('{"lui_x0",   enc_u(20'hABCDE, 5'd0, 7'h37),                  0,  32'h00000000, 32'd20});
        vecs.push_back('{"ill_sub3", enc_r(7'h20, 5'd3, 5'd1, 3'd1, 5'd10),          10, 32'h00000000, 32'd20});
        vecs.push_back('{"ill_f7",   enc_r(7'h01, 5'd3, 5'd1, 3'd0, 5'd10),          10, 32'h00000000, 32'd20});
        vecs.push_back('{"ill_opc",  32'h0000057F,                                   10, 32'h00000000, 32'd20});
        vecs.push_back('{"ill_slli", enc_i(12'h401, 5'd1, 3'd1, 5'd10, 7'h13),       10, 32'h00000000, 32'd20});
        vecs.push_back('{"ill_jalr", enc_i(12'h020, 5'd3, 3'd1, 5'd10, 7'h67),       10, 32'h00000000, 32'd20});
        vecs.push_back('{"jal",      enc_j(21'h000100, 5'd10),                       10, 32'd20,       32'h110});
        vecs.push_back('{"jalr",     enc_i(12'h020, 5'd3, 3'd0, 5'd10, 7'h67),       10, 32'd20,       32'h26});
        vecs.push_back('{"beq_t",    enc_b(13'd12, 5'd3, 5'd3, 3'd0),                0,  32'd0,        32'd28});
        vecs.push_back('{"bne_nt",   enc_b(13'd12, 5'd3, 5'd3, 3'd1),                0,  32'd0,        32'd20});
        vecs.push_back('{"blt_t",    enc_b(13'd8,  5'd3, 5'd1, 3'd4),                0,  32'd0,        32'd24});
        vecs.push_back('{"bltu_nt",  enc_b(13'd8,  5'd3, 5'd1, 3'd6),                0,  32'd0,        32'd20});
        vecs.push_back('{"bltu_t",   enc_b(13'd8,  5'd2, 5'd3, 3'd6),                0,  32'd0,        32'd24});
        vecs.push_back('{"bge_back", enc_b(13'h1FF0, 5'd1, 5'd2, 3'd5),              0,  32'd0,        32'd0});
        vecs.push_back('{"bge_eq",   enc_b(13'd8,  5'd3, 5'd3, 3'd5),                0,  32'd0,        32'd24});
        vecs.push_back('{"bgeu_nt",  enc_b(13'd8,  5'd2, 5'd3, 3'd7),                0,  32'd0,        32'd20});
        vecs.push_back('{"ill_br",   enc_b(13'd12, 5'd3, 5'd3, 3'd2),                0,  32'd0,        32'd20});

        for (int unsigned k = 0; k < 32'(vecs.size()); k++) begin
            imem_write(32'h10, vecs[k].instr);
            rst = 1'b0;
            run(5);
            if (k == 0) begin
                check("setup_x1", xreg(1), 32'h80000005);
                check("setup_x2", xreg(2), 32'hFFFFFFFD);
                check("setup_x3", xreg(3), 32'h00000007);
            end
            check(vecs[k].name, xreg(vecs[k].rd), vecs[k].exp_rd);
            check({vecs[k].name, "_pc"}, dut.r_pc, vecs[k].exp_pc);
            rst = 1'b1;
        end

        // Reference program
        imem_write(32'h00, 32'h00C08113);
        imem_write(32'h04, 32'h00022037);
        imem_write(32'h08, 32'h002151B3);
        imem_write(32'h0C, 32'h00200093);
        rst = 1'b0;
        run(4);
        check("ref_x2", xreg(2), 32'd12);
        check("ref_x0", xreg(0), 32'd0);
        check("ref_x3", xreg(3), 32'd0);
        check("ref_x1", xreg(1), 32'd2);
        rst = 1'b1;

        // Arithmetic vs logical shift of all-ones
        imem_write(32'h00, addi(5'd1, 5'd0, 12'hFFF));
        imem_write(32'h04, enc_i(12'h404, 5'd1, 3'd5, 5'd2, 7'h13));
        imem_write(32'h08, enc_i(12'h01C, 5'd1, 3'd5, 5'd3, 7'h13));
        rst = 1'b0;
        run(3);
        check("shift_x2", xreg(2), 32'hFFFFFFFF);
        check("shift_x3", xreg(3), 32'h0000000F);
        rst = 1'b1;

        // Countdown loop, then an asynchronous abort mid-loop and a rerun
        imem_write(32'h00, addi(5'd1, 5'd0, 12'h003));
        imem_write(32'h04, addi(5'd1, 5'd1, 12'hFFF));
        imem_write(32'h08, enc_b(13'h1FFC, 5'd0, 5'd1, 3'd1));
        imem_write(32'h0C, NOP);
        rst = 1'b0;
        run(3);
        check("loop_c3_x1", xreg(1), 32'd2);
        check("loop_c3_pc", dut.r_pc, 32'd4);
        run(4);
        check("loop_exit_x1", xreg(1), 32'd0);
        check("loop_exit_pc", dut.r_pc, 32'd12);
        run(1);
        check("loop_after_pc", dut.r_pc, 32'd16);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        run(4);
        check("abort_pre_x1", xreg(1), 32'd1);
        check("abort_pre_pc", dut.r_pc, 32'd8);
        #2 rst = 1'b1;
        #1;
        check("abort_pc", dut.r_pc, 32'd0);
        check("abort_x1", xreg(1), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run(7);
        check("rerun_x1", xreg(1), 32'd0);
        check("rerun_pc", dut.r_pc, 32'd12);
        rst = 1'b1;

        // JAL skips the word at 0x14
        for (int unsigned a = 0; a < 16; a += 4)
            imem_write(32'(a), NOP);
        imem_write(32'h10, enc_j(21'd8, 5'd5));
        imem_write(32'h14, addi(5'd6, 5'd0, 12'h001));
        imem_write(32'h18, addi(5'd7, 5'd0, 12'h002));
        rst = 1'b0;
        run(5);
        check("jal_x5", xreg(5), 32'h14);
        check("jal_pc", dut.r_pc, 32'h18);
        run(1);
        check("jal_x7", xreg(7), 32'd2);
        check("jal_x6_skipped", xreg(6), 32'd0);
        rst = 1'b1;

        // Out-of-range debug writes are dropped; low address bits are ignored
        imem_write(32'h000, addi(5'd2, 5'd0, 12'h002));
        imem_write(32'h004, addi(5'd1, 5'd0, 12'h001));
        imem_write(32'h400, addi(5'd5, 5'd0, 12'h055));
        imem_write(32'h007, addi(5'd3, 5'd0, 12'h003));
        imem_write(32'h404, addi(5'd4, 5'd0, 12'h004));
        rst = 1'b0;
        run(2);
        check("dbg_w0_x2", xreg(2), 32'd2);
        check("dbg_oor_x5", xreg(5), 32'd0);
        check("dbg_a7_x3", xreg(3), 32'd3);
        check("dbg_a7_x1", xreg(1), 32'd0);
        check("dbg_oor_x4", xreg(4), 32'd0);
        rst = 1'b1;

        // Write to the word being fetched: old word executes, new word next time
        imem_write(32'h00, addi(5'd1, 5'd0, 12'h001));
        imem_write(32'h04, addi(5'd2, 5'd0, 12'h002));
        imem_write(32'h08, addi(5'd3, 5'd0, 12'h003));
        rst = 1'b0;
        run(1);
        imem_write(32'h04, addi(5'd2, 5'd0, 12'h022));
        check("same_cyc_x2_old", xreg(2), 32'd2);
        run(1);
        check("same_cyc_x3", xreg(3), 32'd3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        run(2);
        check("same_cyc_x2_new", xreg(2), 32'h22);
        rst = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cpu_core.md
CPU_CORE -- requirements
Module: cpu_core

Interface
REQ-001 Parameter XLEN, default 32, datapath/register width; only 32 is supported.
REQ-002 Parameter IMEM_DEPTH, default 256, instruction memory depth in 32-bit words; must be a power of two.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 dbg_wr_en  input  1  instruction-memory write strobe, sampled on rising clk.
REQ-006 dbg_addr  input  XLEN  byte address of the instruction word to write.
REQ-007 dbg_instr  input  XLEN  instruction word to write.

Function
REQ-008 Core SHALL execute RV32I OP (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND), OP-IMM (ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI), LUI, AUIPC, JAL, JALR and BRANCH (BEQ, BNE, BLT, BGE, BLTU, BGEU).
REQ-009 Core is single-cycle: with rst low, it fetches, executes and writes back one instruction per rising clk edge, with no stalls.
REQ-010 Any other opcode, or an illegal funct3/funct7 combination, SHALL execute as a NOP (PC+4, no register write).
REQ-011 Instruction memory SHALL be IMEM_DEPTH words; fetch index = pc[log2(IMEM_DEPTH)+1:2], so PC wraps modulo 4*IMEM_DEPTH.
REQ-012 Debug write: on a rising clk edge with dbg_wr_en=1, imem[dbg_addr[log2(IMEM_DEPTH)+1:2]] <= dbg_instr; dbg_addr[1:0] is ignored.
REQ-013 Debug writes with dbg_addr >= 4*IMEM_DEPTH SHALL be ignored.
REQ-014 Debug writes SHALL be accepted whether rst is high or low.
REQ-015 A debug write to the word fetched in the same cycle SHALL leave that cycle executing the old word; the new word is visible from the next cycle.
REQ-016 Register file: 32 x XLEN; x0 reads 0 and writes to x0 are discarded; two combinational read ports and one write port.
REQ-017 Arithmetic wraps modulo 2^32; shift amounts use rs2[4:0] or imm[4:0]; SLT/BLT/BGE compare signed, SLTU/BLTU/BGEU compare unsigned.
REQ-018 Immediates are sign-extended per the RV32I I/S/B/U/J formats.
REQ-019 Branch/JAL target = pc+imm; JALR target = (rs1+imm) with bit 0 cleared; JAL/JALR write pc+4 to rd.
REQ-020 Target misalignment SHALL NOT trap; pc[1:0] is ignored for fetch.

Reset
REQ-021 While rst is high: pc=0, all registers x1..x31 = 0, no instruction executes.
REQ-022 Reset SHALL NOT clear instruction memory; power-up contents are 0x00000013 (NOP).
REQ-023 After rst deasserts, the first rising edge executes imem[0].
REQ-024 Asserting rst mid-program SHALL abort immediately; after release, execution restarts at address 0 with zeroed registers.

Configuration
REQ-025 Macro CPU_CORE_DBG_REGFILE_EN, when defined, adds input dbg_reg_sel[4:0] and output dbg_reg_data[XLEN-1:0], driven combinationally with x[dbg_reg_sel] (0 when dbg_reg_sel=0).
REQ-026 Without CPU_CORE_DBG_REGFILE_EN, the port list is exactly REQ-003..REQ-007 and behaviour is otherwise identical.

Structure
REQ-027 Package cpu_core_pkg SHALL hold the opcode enum, the ALU-operation enum, funct3/funct7 constants and the NOP constant 0x00000013.
REQ-028 The ALU SHALL be a separate sub-module cpu_core_alu (two XLEN operands, ALU-op select, XLEN result, compare flags); all other logic lives in cpu_core.

Verification
REQ-029 During reset, load 0x00C08113@0, 0x00022037@4, 0x002151B3@8, 0x00200093@12, then release rst -> after 4 cycles x2=12, x0=0, x3=0, x1=2.
REQ-030 ADDI x1,x0,-1; SRAI x2,x1,4; SRLI x3,x1,28 -> x2=0xFFFFFFFF, x3=0x0000000F.
REQ-031 ADDI x1,x0,3; loop ADDI x1,x1,-1; BNE x1,x0,-4 -> loop exits with x1=0 after 7 cycles total, then PC continues at loop+8.
REQ-032 JAL x5,+8 at address 0x10 -> x5=0x14, next fetch at 0x18; the instruction at 0x14 is not executed.
REQ-033 Debug write with dbg_addr=4*IMEM_DEPTH -> imem unchanged; write with dbg_addr=0x7 -> updates word 1.
REQ-034 Assert rst mid-loop -> pc=0 and registers=0 immediately; imem is intact and the program reruns identically after release.
